// File: rtl/seqdet_pkg.sv
// Shared definitions for the serializer / sequence-detector slice.
//   - Serializer state encoding (IDLE/SHIFT/PARITY) and its enum type.
//   - Detector pattern constants SEQ_PATTERN / SEQ_LEN.
//   - par_step: one step of a running even-parity accumulation.
package seqdet_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SHIFT  = SHIFT,
    ST_PARITY = PARITY
  } ser_state_e;

  localparam logic [4:0] SEQ_PATTERN = 5'b01101;
  localparam int         SEQ_LEN     = 5;

  // Fold one more emitted bit into the running parity.
  function automatic logic par_step(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word-input handshake of bit_serializer.
//   in_data  : parallel word (master -> slave)
//   in_valid : word valid     (master -> slave)
//   in_ready : slave can take a word this cycle (slave -> master)
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bit_serializer_parity_acc.sv
// ser_parity_acc: running XOR of the data bits of the word in flight.
// Only compiled when SER_PARITY_EN is defined (the only build that uses it).
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : word accepted, restart accumulation
//   en         : a data bit is being emitted this cycle
//   bit_in     : the data bit being emitted
//   par        : even parity of the bits emitted since the last clr
`ifdef SER_PARITY_EN
module ser_parity_acc
  import seqdet_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic par
);

  // Parity accumulator register; a new word always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par <= 1'b0;
    end else if (clr) begin
      par <= 1'b0;
    end else if (en) begin
      par <= par_step(par, bit_in);
    end else begin
      par <= par;
    end
  end

endmodule
`endif

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial stage feeding a serial sequence detector.
// Accepts WIDTH-bit words over in_if and emits one bit per bit_en strobe.
// A new word may be accepted in the final-bit cycle, so consecutive words
// stream out with no gap.
// Optional feature macro: SER_PARITY_EN appends an even-parity bit to every
// word (frame becomes WIDTH+1 bits, back-to-back window moves to that bit).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_if        : slave side of the word handshake (in_ready combinational)
//   bit_en       : bit-rate strobe
//   x            : registered serial bit
//   x_valid      : registered, 1 the cycle after an emitting bit_en
//   frame_start  : registered, marks the first bit of each word
//   busy         : state is not IDLE
module bit_serializer
  import seqdet_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit IDLE_BIT  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bit_serializer_if.slave       in_if,
  input  logic                  bit_en,
  output logic                  x,
  output logic                  x_valid,
  output logic                  frame_start,
  output logic                  busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_e       state_r, state_nxt_s;
  logic [WIDTH-1:0] shreg_r, shreg_nxt_s, shreg_shift_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             x_nxt_s, x_valid_nxt_s, frame_start_nxt_s;
  logic             cur_bit_s, last_bit_s, ready_s, accept_s;

  // The bit on the output end of the shift register is always the next one out.
  assign cur_bit_s     = LSB_FIRST ? shreg_r[0] : shreg_r[WIDTH-1];
  assign shreg_shift_s = LSB_FIRST ? {1'b0, shreg_r[WIDTH-1:1]}
                                   : {shreg_r[WIDTH-2:0], 1'b0};
  assign last_bit_s    = (state_r == ST_SHIFT) && (cnt_r == CNT_LAST);

`ifdef SER_PARITY_EN
  logic par_s;
  logic data_emit_s;

  assign data_emit_s = (state_r == ST_SHIFT) && bit_en;
  // Back-to-back window sits on the parity-bit cycle.
  assign ready_s     = (state_r == ST_IDLE) || ((state_r == ST_PARITY) && bit_en);

  ser_parity_acc u_parity_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept_s),
    .en     (data_emit_s),
    .bit_in (cur_bit_s),
    .par    (par_s)
  );
`else
  // Back-to-back window sits on the last data bit.
  assign ready_s = (state_r == ST_IDLE) || (last_bit_s && bit_en);
`endif

  assign in_if.in_ready = ready_s;
  assign accept_s       = in_if.in_valid && ready_s;
  assign busy           = (state_r != ST_IDLE);

  // Next-state, datapath and output-register inputs.
  always_comb begin
    state_nxt_s       = state_r;
    shreg_nxt_s       = shreg_r;
    cnt_nxt_s         = cnt_r;
    x_nxt_s           = x;
    x_valid_nxt_s     = 1'b0;
    frame_start_nxt_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bit_en) begin
          x_nxt_s = IDLE_BIT;
        end else begin
          x_nxt_s = x;
        end
        // A word accepted here is only loaded; its first bit waits for a later strobe.
        if (accept_s) begin
          shreg_nxt_s = in_if.in_data;
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (bit_en) begin
          x_nxt_s           = cur_bit_s;
          x_valid_nxt_s     = 1'b1;
          frame_start_nxt_s = (cnt_r == CNT_ZERO);
          shreg_nxt_s       = shreg_shift_s;
          if (last_bit_s) begin
            cnt_nxt_s = CNT_ZERO;
`ifdef SER_PARITY_EN
            state_nxt_s = ST_PARITY;
`else
            if (accept_s) begin
              shreg_nxt_s = in_if.in_data;
              state_nxt_s = ST_SHIFT;
            end else begin
              state_nxt_s = ST_IDLE;
            end
`endif
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          x_nxt_s = x;
        end
      end

`ifdef SER_PARITY_EN
      ST_PARITY: begin
        if (bit_en) begin
          x_nxt_s       = par_s;
          x_valid_nxt_s = 1'b1;
          if (accept_s) begin
            shreg_nxt_s = in_if.in_data;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ST_SHIFT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          x_nxt_s = x;
        end
      end
`endif

      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, shift register, counter and registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      shreg_r     <= {WIDTH{1'b0}};
      cnt_r       <= CNT_ZERO;
      x           <= IDLE_BIT;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      shreg_r     <= shreg_nxt_s;
      cnt_r       <= cnt_nxt_s;
      x           <= x_nxt_s;
      x_valid     <= x_valid_nxt_s;
      frame_start <= frame_start_nxt_s;
    end
  end

endmodule
